inv_cube_seq: RTL

Parametrised sequential successor to the fixed 11×11 inverse-distance-cube lookup. It computes a scaled inverse cube of the Euclidean distance for any (x_dist, y_dist) within the port widths, using a squarer, an iterative integer square root and an iterative restoring divider. It sits between the neighbour-scan logic and the field accumulator. One request is in flight at a time, with valid/ready handshakes on input and output.

---
 rtl/inv_cube_seq_if.sv | 28 ++
 rtl/inv_cube_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/inv_cube_seq_if.sv
// inv_cube_seq_if
// Request/response bundle for the inverse-distance-cube unit.
//   in_valid / in_ready         : request handshake (x_dist, y_dist)
//   out_valid / out_ready       : response handshake (inv_distance_cube)
// master: the requester/consumer side. slave: the computing block.
interface inv_cube_seq_if #(
  parameter int XW = 7,
  parameter int YW = 6,
  parameter int OW = 20
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x_dist;
  logic [YW-1:0] y_dist;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] inv_distance_cube;

  modport master (
    output in_valid, x_dist, y_dist, out_ready,
    input  in_ready, out_valid, inv_distance_cube
  );

  modport slave (
    input  in_valid, x_dist, y_dist, out_ready,
    output in_ready, out_valid, inv_distance_cube
  );
endinterface

// File: rtl/inv_cube_seq.sv
// inv_cube_seq
// Sequential scaled inverse cube of the Euclidean distance:
//   s = x^2 + y^2, r = floor(sqrt(s)), D = s*r,
//   result = min(floor(2^SHIFT / D), 2^OW - 1), and 0 when s == 0.
// One request in flight. Fixed latency: out_valid rises RW+SHIFT+4 edges
// after the accept edge, whatever the operands.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : inv_cube_seq_if.slave (in_valid/in_ready/x_dist/y_dist,
//           out_valid/out_ready/inv_distance_cube)
module inv_cube_seq #(
  parameter int XW    = 7,
  parameter int YW    = 6,
  parameter int OW    = 20,
  parameter int SHIFT = 23
) (
  input  logic          clk,
  input  logic          reset,
  inv_cube_seq_if.slave bus
);
  localparam int SW = ((XW > YW) ? 2 * XW : 2 * YW) + 1;
  localparam int RW = (SW + 1) / 2;
  localparam int DW = SW + RW;
  localparam int CW = $clog2((RW > SHIFT + 1) ? RW : SHIFT + 1);
  localparam int MW = (SHIFT + 1 > OW) ? SHIFT + 1 : OW;

  typedef enum logic [2:0] {
    S_IDLE, S_SQUARE, S_SQRT, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [SW-1:0]   r_s;
  logic [2*RW-1:0] r_sq;     // radicand, consumed two bits per step from the top
  logic [RW:0]     r_rem;    // square-root partial remainder
  logic [RW-1:0]   r_root;
  logic [DW-1:0]   r_d;
  logic [DW:0]     r_p;      // divider partial remainder
  logic [SHIFT:0]  r_q;      // dividend shifts out the top, quotient in the bottom
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;
  logic [OW-1:0]   r_result;

  function automatic logic [OW-1:0] sat_q(input logic [SHIFT:0] q);
    logic [MW-1:0] qe;
    qe = MW'(q);
    if (qe > MW'({OW{1'b1}})) return {OW{1'b1}};
    return qe[OW-1:0];
  endfunction

  logic [SW-1:0] w_s;
  assign w_s = SW'(r_x) * SW'(r_x) + SW'(r_y) * SW'(r_y);

  // Square-root step: bring down the next bit pair, try subtracting 4*root+1.
  // The compare uses the full width; the difference is known to fit RW+1 bits,
  // so it is taken modulo 2^(RW+1).
  logic [RW+2:0] w_rem_t, w_trial;
  logic          w_sqrt_ge;
  logic [RW:0]   w_rem_new;
  assign w_rem_t   = {r_rem, r_sq[2*RW-1 -: 2]};
  assign w_trial   = {1'b0, r_root, 2'b01};
  assign w_sqrt_ge = (w_rem_t >= w_trial);
  assign w_rem_new = w_sqrt_ge ? (w_rem_t[RW:0] - w_trial[RW:0]) : w_rem_t[RW:0];

  // Divider step: same full-width compare / truncated subtract pattern.
  logic [DW+1:0] w_p_t;
  logic          w_div_ge;
  logic [DW:0]   w_p_new;
  assign w_p_t    = {r_p, r_q[SHIFT]};
  assign w_div_ge = (w_p_t >= (DW+2)'(r_d));
  assign w_p_new  = w_div_ge ? (w_p_t[DW:0] - {1'b0, r_d}) : w_p_t[DW:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid) w_next = S_SQUARE;
      S_SQUARE: w_next = S_SQRT;
      S_SQRT:   if (r_cnt == '0) w_next = S_MUL;
      S_MUL:    w_next = S_DIV;
      S_DIV:    if (r_cnt == '0) w_next = S_DONE;
      S_DONE:   if (r_out_valid && bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_s         <= '0;
      r_sq        <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x <= bus.x_dist;
            r_y <= bus.y_dist;
          end
        end
        S_SQUARE: begin
          r_s    <= w_s;
          r_sq   <= (2*RW)'(w_s);
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= CW'(RW - 1);
        end
        S_SQRT: begin
          r_sq   <= {r_sq[2*RW-3:0], 2'b00};
          r_rem  <= w_rem_new;
          r_root <= {r_root[RW-2:0], w_sqrt_ge};
          r_cnt  <= r_cnt - CW'(1);
        end
        S_MUL: begin
          r_d   <= DW'(r_s) * DW'(r_root);
          r_p   <= '0;
          r_q   <= (SHIFT+1)'(1) << SHIFT;
          r_cnt <= CW'(SHIFT);
        end
        S_DIV: begin
          r_p   <= w_p_new;
          r_q   <= {r_q[SHIFT-1:0], w_div_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_DONE: begin
          // First DONE cycle registers the result; out_valid then holds
          // until the consumer takes it. s == 0 would have divided by zero.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= (r_s == '0) ? '0 : sat_q(r_q);
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready          = (r_state == S_IDLE);
  assign bus.out_valid         = r_out_valid;
  assign bus.inv_distance_cube = r_result;
endmodule
